commit_order_sched: RTL

//  Tracks the issue order of instructions dispatched to the execution units
//  and lets each unit's held result retire only when it is the oldest one

---
 rtl/commit_order_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/commit_order_sched.sv
// commit_order_sched
//   Keeps the issue order of instructions sent to the execution units. A unit
//   that holds a finished result may hand it to commit only when its record is
//   the oldest one still outstanding. This gives in-order retirement.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   issue_valid  push one issue record this cycle
//   issue_unit   unit id of the pushed record (0..NUNITS-1)
//   issue_ready  table not full; a push is accepted only while high
//   unit_done    per-unit pulse: the unit holds a result and wants to commit
//   commit_grant one-hot; this unit may hand its result to commit now
//   unit_stall   the unit holds a result but is not granted
//   count        number of valid entries in the table
//   flush        discard all outstanding records and pending results
//   proto_err    sticky protocol-error flag
module commit_order_sched #(
   parameter int DEPTH  = 8,
   parameter int NUNITS = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic [2:0]               issue_unit,
   output logic                     issue_ready,
   input  logic [NUNITS-1:0]        unit_done,
   output logic [NUNITS-1:0]        commit_grant,
   output logic [NUNITS-1:0]        unit_stall,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     flush,
   output logic                     proto_err
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [3:0]  NUNITS_L = 4'(NUNITS);

   logic [2:0]        mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [NUNITS-1:0] done_pend;

   logic full;
   logic empty;
   logic unit_ok;
   logic push;
   logic pop;
   logic bad_issue;
   logic double_done;
   logic [2:0] head;

   assign full        = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign issue_ready = ~full;
   assign unit_ok     = ({1'b0, issue_unit} < NUNITS_L);
   assign push        = issue_valid & issue_ready & unit_ok;
   // An out-of-range id is only an error when the push would otherwise have
   // been accepted; a push while full is silently dropped.
   assign bad_issue   = issue_valid & issue_ready & ~unit_ok;
   assign head        = mem[rd_ptr];

   // Grant depends only on registered state, so it is stable for the whole
   // cycle and never combinationally loops back from the units.
   always_comb begin
      commit_grant = '0;
      for (int u = 0; u < NUNITS; u++) begin
         commit_grant[u] = ~empty & ({1'b0, head} == 4'(u)) & done_pend[u];
      end
   end

   assign pop         = |commit_grant;
   assign unit_stall  = done_pend & ~commit_grant;
   // A second result while the first is still waiting would be lost.
   assign double_done = |(unit_done & done_pend & ~commit_grant);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         done_pend <= '0;
         proto_err <= 1'b0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         done_pend <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         // A new done pulse wins over the grant clearing the same bit.
         done_pend <= (done_pend & ~commit_grant) | unit_done;
         if (bad_issue || double_done) proto_err <= 1'b1;
      end
   end

   // Table contents carry no reset; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push && !rst && !flush) mem[wr_ptr] <= issue_unit;
   end

endmodule
